// File: rtl/can_frame_rx.sv
// Bit-serial receiver for a fixed-length CAN-style frame, mid-bit sampled.
// Ports: i_Clock, i_Rst_L (async low), i_Rx_Serial in; o_Rx_DV strobe,
// o_Rx_Byte[78:0] frame word (bit k = k-th bit received, start at 0).
// Optional: define CAN_RX_FRAME_ERR_EN to add o_Frame_Err, which pulses on
// a stop-bit framing error or a start-bit glitch.
module can_frame_rx #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic        i_Clock,
    input  logic        i_Rst_L,
    input  logic        i_Rx_Serial,
    output logic        o_Rx_DV,
`ifdef CAN_RX_FRAME_ERR_EN
    output logic        o_Frame_Err,
`endif
    output logic [78:0] o_Rx_Byte
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] BITS    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] CLEANUP = 3'd4;

    logic          r_Sync1;
    logic          r_Sync2;
    logic [2:0]    r_State;
    logic [CW-1:0] r_Clk_Cnt;
    logic [6:0]    r_Bit_Idx;
    logic [78:0]   r_Shift;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Sync1 <= 1'b1;
            r_Sync2 <= 1'b1;
        end else begin
            r_Sync1 <= i_Rx_Serial;
            r_Sync2 <= r_Sync1;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State   <= IDLE;
            r_Clk_Cnt <= '0;
            r_Bit_Idx <= '0;
            r_Shift   <= '1;
            o_Rx_DV   <= 1'b0;
            o_Rx_Byte <= '0;
`ifdef CAN_RX_FRAME_ERR_EN
            o_Frame_Err <= 1'b0;
`endif
        end else begin
            // strobes are single-cycle unless re-asserted below
            o_Rx_DV <= 1'b0;
`ifdef CAN_RX_FRAME_ERR_EN
            o_Frame_Err <= 1'b0;
`endif
            unique case (r_State)
                IDLE: begin
                    r_Clk_Cnt <= '0;
                    if (!r_Sync2) r_State <= START;
                end
                START: begin
                    if (r_Clk_Cnt == HALF) begin
                        r_Clk_Cnt <= '0;
                        if (!r_Sync2) begin
                            r_Shift[0] <= 1'b0;
                            r_Bit_Idx  <= 7'd1;
                            r_State    <= BITS;
                        end else begin
                            r_State <= IDLE;
`ifdef CAN_RX_FRAME_ERR_EN
                            o_Frame_Err <= 1'b1;
`endif
                        end
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
                    end
                end
                BITS: begin
                    if (r_Clk_Cnt != FULL) begin
                        r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
                    end else begin
                        r_Clk_Cnt          <= '0;
                        r_Shift[r_Bit_Idx] <= r_Sync2;
                        if (r_Bit_Idx == 7'd78) r_State <= STOP;
                        else r_Bit_Idx <= r_Bit_Idx + 1'b1;
                    end
                end
                STOP: begin
                    if (r_Clk_Cnt != FULL) begin
                        r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
                    end else begin
                        r_Clk_Cnt <= '0;
                        r_State   <= CLEANUP;
                        if (r_Sync2) begin
                            o_Rx_Byte <= r_Shift;
                            o_Rx_DV   <= 1'b1;
                        end else begin
`ifdef CAN_RX_FRAME_ERR_EN
                            o_Frame_Err <= 1'b1;
`endif
                        end
                    end
                end
                CLEANUP: begin
                    r_State <= IDLE;
                end
                default: begin
                    r_State <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_frame_rx.sv
// Self-checking bench for can_frame_rx: vector table, corner sequences
// and randomized frames against a field-level frame model.
module tb_can_frame_rx;

    localparam int CPB = 10;

    logic        i_Clock = 1'b0;
    logic        i_Rst_L = 1'b0;
    logic        i_Rx_Serial = 1'b1;
    logic        o_Rx_DV;
    logic [78:0] o_Rx_Byte;
`ifdef CAN_RX_FRAME_ERR_EN
    logic        o_Frame_Err;
`endif

    can_frame_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock    (i_Clock),
        .i_Rst_L    (i_Rst_L),
        .i_Rx_Serial(i_Rx_Serial),
        .o_Rx_DV    (o_Rx_DV),
`ifdef CAN_RX_FRAME_ERR_EN
        .o_Frame_Err(o_Frame_Err),
`endif
        .o_Rx_Byte  (o_Rx_Byte)
    );

    always #5 i_Clock = ~i_Clock;

    int checks = 0;
    int failures = 0;
    int dv_cnt = 0;
    int err_cnt = 0;
    logic [78:0] cap_q[$];

    always @(negedge i_Clock) begin
        if (o_Rx_DV) begin
            dv_cnt++;
            cap_q.push_back(o_Rx_Byte);
        end
`ifdef CAN_RX_FRAME_ERR_EN
        if (o_Frame_Err) err_cnt++;
`endif
    end

    typedef struct {
        logic [10:0] id;
        logic        rtr;
        logic        ide;
        logic        r0;
        logic [63:0] data;
        logic        stop;
        int          exp_dv;
        logic [78:0] exp_byte;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [78:0] make_word(
        input logic [10:0] id, input logic rtr, input logic ide,
        input logic r0, input logic [63:0] data);
        return {data, r0, ide, rtr, id, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [78:0] act,
                       input logic [78:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        i_Rx_Serial = b;
        repeat (CPB) @(negedge i_Clock);
    endtask

    task automatic send_frame(input logic [78:0] w, input logic stop);
        for (int i = 0; i < 79; i++) send_bit(w[i]);
        send_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        i_Rx_Serial = 1'b1;
        repeat (n * CPB) @(negedge i_Clock);
    endtask

    logic [78:0] nominal;
    logic [78:0] hold;
    logic [78:0] w1;
    logic [78:0] w2;
    int          dv0;
    int          err0;

    initial begin
        nominal = {64'hAAAA_AAAA_AAAA_AAAA, 15'h0028};

        vecs[0] = '{11'h014, 1'b0, 1'b0, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA,
                    1'b1, 1, {64'hAAAA_AAAA_AAAA_AAAA, 15'h0028}};
        vecs[1] = '{11'h7FF, 1'b1, 1'b0, 1'b1, 64'h1,
                    1'b1, 1, {64'h1, 15'h5FFE}};
        vecs[2] = '{11'h014, 1'b0, 1'b0, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA,
                    1'b0, 0, {64'h1, 15'h5FFE}};
        vecs[3] = '{11'h555, 1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567,
                    1'b1, 1, {64'hDEAD_BEEF_0123_4567, 15'h7AAA}};

        repeat (3) @(negedge i_Clock);
        chk("reset_byte", o_Rx_Byte, 79'd0);
        chk("reset_dv", {78'd0, o_Rx_DV}, 79'd0);
        i_Rst_L = 1'b1;
        idle_bits(2);

        for (int i = 0; i < 4; i++) begin
            dv0 = dv_cnt;
            err0 = err_cnt;
            send_frame(make_word(vecs[i].id, vecs[i].rtr, vecs[i].ide,
                                 vecs[i].r0, vecs[i].data), vecs[i].stop);
            i_Rx_Serial = 1'b1;
            @(negedge i_Clock);
            chk($sformatf("vec%0d_dv", i), 79'(dv_cnt - dv0),
                79'(vecs[i].exp_dv));
            chk($sformatf("vec%0d_byte", i), o_Rx_Byte, vecs[i].exp_byte);
`ifdef CAN_RX_FRAME_ERR_EN
            chk($sformatf("vec%0d_err", i), 79'(err_cnt - err0),
                79'(1 - vecs[i].exp_dv));
`endif
            idle_bits(2);
        end
        hold = vecs[3].exp_byte;

        // short low glitch on an idle line
        dv0 = dv_cnt;
        err0 = err_cnt;
        i_Rx_Serial = 1'b0;
        repeat (3) @(negedge i_Clock);
        i_Rx_Serial = 1'b1;
        idle_bits(3);
        chk("glitch_dv", 79'(dv_cnt - dv0), 79'd0);
        chk("glitch_byte", o_Rx_Byte, hold);
`ifdef CAN_RX_FRAME_ERR_EN
        chk("glitch_err", 79'(err_cnt - err0), 79'd1);
`endif
        dv0 = dv_cnt;
        send_frame(nominal, 1'b1);
        idle_bits(1);
        chk("post_glitch_dv", 79'(dv_cnt - dv0), 79'd1);
        chk("post_glitch_byte", o_Rx_Byte, nominal);

        // reset in the middle of a frame
        dv0 = dv_cnt;
        for (int i = 0; i < 40; i++) send_bit(w1[0] & 1'b0 | nominal[i]);
        i_Rx_Serial = 1'b1;
        i_Rst_L = 1'b0;
        @(negedge i_Clock);
        chk("midrst_byte", o_Rx_Byte, 79'd0);
        chk("midrst_dv", {78'd0, o_Rx_DV}, 79'd0);
        @(negedge i_Clock);
        i_Rst_L = 1'b1;
        idle_bits(2);
        send_frame(nominal, 1'b1);
        idle_bits(1);
        chk("midrst_after_dv", 79'(dv_cnt - dv0), 79'd1);
        chk("midrst_after_byte", o_Rx_Byte, nominal);

        // back-to-back frames with no idle gap
        w1 = make_word(11'h123, 1'b0, 1'b0, 1'b0, 64'h1);
        w2 = make_word(11'h456, 1'b0, 1'b1, 1'b0, 64'h2);
        cap_q.delete();
        dv0 = dv_cnt;
        send_frame(w1, 1'b1);
        send_frame(w2, 1'b1);
        idle_bits(1);
        chk("b2b_dv", 79'(dv_cnt - dv0), 79'd2);
        if (cap_q.size() == 2) begin
            chk("b2b_data1", 79'(cap_q[0][78:15]), 79'd1);
            chk("b2b_data2", 79'(cap_q[1][78:15]), 79'd2);
        end else begin
            checks++;
            failures++;
            $display("FAIL b2b_capture: got %0d pulses expected 2",
                     cap_q.size());
        end
        hold = w2;

        // randomized frames against the field-level model
        for (int n = 0; n < 20; n++) begin
            logic [10:0] id;
            logic [63:0] data;
            logic [2:0]  f;
            logic        stop;
            logic [78:0] w;
            id   = 11'($urandom);
            data = {$urandom, $urandom};
            f    = 3'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            w    = make_word(id, f[0], f[1], f[2], data);
            dv0  = dv_cnt;
            err0 = err_cnt;
            send_frame(w, stop);
            if (stop) hold = w;
            chk($sformatf("rnd%0d_dv", n), 79'(dv_cnt - dv0),
                stop ? 79'd1 : 79'd0);
            chk($sformatf("rnd%0d_byte", n), o_Rx_Byte, hold);
`ifdef CAN_RX_FRAME_ERR_EN
            chk($sformatf("rnd%0d_err", n), 79'(err_cnt - err0),
                stop ? 79'd0 : 79'd1);
`endif
            idle_bits($urandom_range(0, 2));
        end

        idle_bits(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
